// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - writable instruction memory with registered fetch port and reset-time zero-fill
// Optional IMEM_PARITY_EN adds a stored even-parity bit, a par_err output and a par_flip test input.
module imem_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_rdy,
  input  logic                  fetch_stall,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  misalign,
`ifdef IMEM_PARITY_EN
  output logic                  par_err,
  input  logic                  par_flip,
`endif
  input  logic                  wr_ena,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  init_done
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef IMEM_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif

  logic [MEM_WIDTH-1:0] mem [DEPTH];
  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] cnt;
  logic                 run;
  logic                 fetch_go;
  logic                 rd_aligned;
  logic                 rd_in_range;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic                 wr_ok;
  logic [MEM_WIDTH-1:0] wr_word;
  logic [MEM_WIDTH-1:0] rd_word;

  assign run       = (state == RUN);
  assign init_done = run;
  assign fetch_rdy = run && !fetch_stall;
  assign fetch_go  = fetch_req && fetch_rdy;

  // Range checks use the untruncated word index so high addresses never alias.
  assign rd_aligned  = (pc[1:0] == 2'b00);
  assign rd_in_range = ((pc >> 2) < ADDR_WIDTH'(DEPTH));
  assign rd_idx      = pc[IDX_WIDTH+1:2];
  assign wr_idx      = wr_addr[IDX_WIDTH+1:2];
  assign wr_ok       = run && wr_ena && (wr_addr[1:0] == 2'b00) &&
                       ((wr_addr >> 2) < ADDR_WIDTH'(DEPTH));

`ifdef IMEM_PARITY_EN
  assign wr_word = {(^wr_data) ^ par_flip, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Write-first: a same-cycle write to the fetched word is forwarded.
  assign rd_word = (wr_ok && (wr_idx == rd_idx)) ? wr_word : mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (!run) begin
      if (cnt == IDX_WIDTH'(DEPTH - 1)) begin
        state <= RUN;
      end else begin
        cnt <= cnt + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
`ifdef IMEM_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else if (run && !fetch_stall) begin
      if (fetch_req) begin
        inst_valid <= 1'b1;
        if (!rd_aligned) begin
          inst     <= '0;
          misalign <= 1'b1;
`ifdef IMEM_PARITY_EN
          par_err  <= 1'b0;
`endif
        end else if (!rd_in_range) begin
          inst     <= '0;
          misalign <= 1'b0;
`ifdef IMEM_PARITY_EN
          par_err  <= 1'b0;
`endif
        end else begin
          inst     <= rd_word[DATA_WIDTH-1:0];
          misalign <= 1'b0;
`ifdef IMEM_PARITY_EN
          par_err  <= rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]);
`endif
        end
      end else begin
        inst_valid <= 1'b0;
        misalign   <= 1'b0;
`ifdef IMEM_PARITY_EN
        par_err    <= 1'b0;
`endif
      end
    end
  end

endmodule
